ps2_kbd_rx: RTL and testbench

Parametrised successor to the fixed PS/2 keyboard receiver: deserialises PS/2 device-to-host frames, checks framing and parity, folds `E0`/`F0` prefixes into flags, and queues decoded key events in a show-ahead FIFO. It sits between the USB-pin PS/2 lines (`usb_fpga_bd_dp`/`dn`) and the CPU/LED/display logic, all in the `clk` domain.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 83 ++++++++
 rtl/ps2_kbd_rx.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
//   ps2_state_e : receive FSM states
//   ps2_evt_t   : queued key event {ext, brk, code}
//   ps2_odd_ok  : odd-parity check over data byte plus parity bit
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    localparam int unsigned PS2_EVT_W = 10;

    // True when data bits plus parity bit hold an odd number of ones.
    function automatic logic ps2_odd_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with registered head, count, full and empty.
//   clk, rst          : clock, async active-high reset
//   i_wr_en/i_wr_data : push (dropped when full unless a pop happens too)
//   i_rd_en           : pop head (ignored when empty)
//   o_rd_data         : head entry, valid while o_empty is low
//   o_count           : entries held, 0..DEPTH
//   o_full, o_empty   : status flags
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic [WIDTH-1:0] r_head;

    logic             w_do_rd;
    logic             w_do_wr;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // A full FIFO still accepts a push when the same cycle pops.
    assign w_do_rd   = i_rd_en & ~r_empty;
    assign w_do_wr   = i_wr_en & (~r_full | w_do_rd);
    assign w_rd_nxt  = r_rd_ptr + PTR_W'(w_do_rd);
    assign w_cnt_nxt = r_count + CNT_W'(w_do_wr) - CNT_W'(w_do_rd);

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers, flags, and the pre-fetched head entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_do_wr);
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
            r_full   <= (w_cnt_nxt == CNT_W'(DEPTH));
            r_empty  <= (w_cnt_nxt == '0);
            // Bypass the write when it lands in the next head slot.
            if (w_cnt_nxt == '0) begin
                r_head <= '0;
            end else if (w_do_wr && (r_wr_ptr == w_rd_nxt)) begin
                r_head <= i_wr_data;
            end else begin
                r_head <= r_mem[w_rd_nxt];
            end
        end
    end

    assign o_rd_data = r_head;
    assign o_count   = r_count;
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, receives
// device-to-host frames, folds E0/F0 prefixes into flags and queues events.
//   clk, reset        : system clock, async active-high reset
//   ps2clk, ps2data   : raw PS/2 lines
//   rd_en             : pop head event when valid
//   valid             : FIFO not empty
//   code/is_ext/is_break : head event fields
//   count             : entries held
//   overflow          : sticky, an event was dropped
//   frame_err         : one-cycle pulse on start/parity/stop error or timeout
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_MHZ    = 25,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FILTER_LEN = 3,
    parameter int unsigned TIMEOUT_US = 2000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2clk,
    input  logic                          ps2data,
    input  logic                          rd_en,
    output logic                          valid,
    output logic [7:0]                    code,
    output logic                          is_ext,
    output logic                          is_break,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FLT_W     = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_CYCLES = CLK_MHZ * TIMEOUT_US;
    localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);

    logic [1:0]             r_rst_sync;
    logic                   w_rst;

    logic                   r_clk_meta;
    logic                   r_clk_s;
    logic                   r_dat_meta;
    logic                   r_dat_s;
    logic [FLT_W-1:0]       r_flt_cnt;
    logic                   r_clk_f;
    logic                   r_clk_f_d;
    logic                   w_fall;
    logic                   w_edge;

    logic [TO_W-1:0]        r_to_cnt;
    logic                   w_timeout;

    ps2_state_e             r_state;
    ps2_state_e             w_state_nxt;

    logic [7:0]             r_shift;
    logic [2:0]             r_bit_cnt;
    logic                   r_par_bad;
    logic                   w_shift_en;
    logic                   w_start_err;
    logic                   w_par_chk;
    logic                   w_par_err;
    logic                   w_stop_err;
    logic                   w_byte_ok;

    logic                   r_ext;
    logic                   r_brk;
    logic                   r_push;
    ps2_evt_t               r_push_evt;
    logic                   r_overflow;
    logic                   r_frame_err;

    logic [PS2_EVT_W-1:0]   w_head_bits;
    ps2_evt_t               w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [CNT_W-1:0]       w_count;

    // Internal reset: asserts immediately, releases on a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end
    assign w_rst = r_rst_sync[1];

    // Two-stage synchronisers; idle PS/2 lines are high.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_clk_meta <= 1'b1;
            r_clk_s    <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_s    <= 1'b1;
        end else begin
            r_clk_meta <= ps2clk;
            r_clk_s    <= r_clk_meta;
            r_dat_meta <= ps2data;
            r_dat_s    <= r_dat_meta;
        end
    end

    // Glitch filter: accept a new clock level after FILTER_LEN equal samples.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_flt_cnt <= '0;
            r_clk_f   <= 1'b1;
            r_clk_f_d <= 1'b1;
        end else begin
            r_clk_f_d <= r_clk_f;
            if (r_clk_s == r_clk_f) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                r_clk_f   <= r_clk_s;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + FLT_W'(1);
            end
        end
    end

    assign w_fall = r_clk_f_d & ~r_clk_f;
    assign w_edge = r_clk_f_d ^ r_clk_f;

    // Inter-edge timeout, only armed inside a frame; an edge takes priority.
    assign w_timeout = (r_state != ST_IDLE) && !w_edge &&
                       (r_to_cnt == TO_W'(TO_CYCLES - 1));

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_to_cnt <= '0;
        end else if (w_edge || (r_state == ST_IDLE)) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_W'(TO_CYCLES - 1)) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; a bad start bit leaves the FSM idle.
    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!r_dat_s) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP:   w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM outputs. After a parity error the stop bit is consumed silently
    // so one bad frame yields exactly one error pulse.
    always_comb begin
        w_shift_en  = 1'b0;
        w_start_err = 1'b0;
        w_par_chk   = 1'b0;
        w_par_err   = 1'b0;
        w_stop_err  = 1'b0;
        w_byte_ok   = 1'b0;
        if (w_fall) begin
            case (r_state)
                ST_IDLE:   w_start_err = r_dat_s;
                ST_DATA:   w_shift_en  = 1'b1;
                ST_PARITY: begin
                    w_par_chk = 1'b1;
                    w_par_err = !ps2_odd_ok(r_shift, r_dat_s);
                end
                ST_STOP: begin
                    w_stop_err = !r_dat_s && !r_par_bad;
                    w_byte_ok  = r_dat_s && !r_par_bad;
                end
                default: ;
            endcase
        end
    end

    // Shift register, prefix decoder, event push and status.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_par_bad   <= 1'b0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_push      <= 1'b0;
            r_push_evt  <= '0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_start_err | w_par_err | w_stop_err | w_timeout;

            if (r_state == ST_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift   <= {r_dat_s, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_par_chk) begin
                r_par_bad <= w_par_err;
            end

            r_push <= 1'b0;
            if (w_par_err || w_stop_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_byte_ok) begin
                if (r_shift == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_shift == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_push          <= 1'b1;
                    r_push_evt.ext  <= r_ext;
                    r_push_evt.brk  <= r_brk;
                    r_push_evt.code <= r_shift;
                    r_ext           <= 1'b0;
                    r_brk           <= 1'b0;
                end
            end

            if (r_push && w_full && !(rd_en && !w_empty)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (PS2_EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (w_rst),
        .i_wr_en   (r_push),
        .i_wr_data (r_push_evt),
        .i_rd_en   (rd_en),
        .o_rd_data (w_head_bits),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_head    = w_head_bits;
    assign valid     = ~w_empty;
    assign code      = w_head.code;
    assign is_ext    = w_head.ext;
    assign is_break  = w_head.brk;
    assign count     = w_count;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx at default parameters.
module tb_ps2_kbd_rx;

    localparam int HP = 10;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       ps2clk  = 1'b1;
    logic       ps2data = 1'b1;
    logic       rd_en   = 1'b0;
    logic       valid;
    logic [7:0] code;
    logic       is_ext;
    logic       is_break;
    logic [3:0] count;
    logic       overflow;
    logic       frame_err;

    int n_chk = 0;
    int n_pass = 0;
    int n_err_pulse = 0;

    ps2_kbd_rx dut (
        .clk       (clk),
        .reset     (reset),
        .ps2clk    (ps2clk),
        .ps2data   (ps2data),
        .rd_en     (rd_en),
        .valid     (valid),
        .code      (code),
        .is_ext    (is_ext),
        .is_break  (is_break),
        .count     (count),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #20 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) n_err_pulse++;

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run did not finish, got %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    // One PS/2 bit: high phase, falling edge, low phase. lat = low-phase edge
    // at which count first changed (-1 if never); rd_en held across edge pop_k.
    task automatic drive_bit(input logic v, input bit glitch, input int pop_k, output int lat);
        logic [3:0] c0;
        ps2data = v;
        lat = -1;
        if (glitch) begin
            repeat (HP/2) @(posedge clk);
            #1 ps2clk = 1'b0;
            @(posedge clk);
            #1 ps2clk = 1'b1;
            repeat (HP/2 - 1) @(posedge clk);
            #1;
        end else begin
            repeat (HP) @(posedge clk);
            #1;
        end
        ps2clk = 1'b0;
        c0 = count;
        for (int k = 1; k <= HP; k++) begin
            rd_en = (k == pop_k);
            ps2clk = (glitch && k == HP - 2);
            @(posedge clk);
            #1;
            if (lat < 0 && count != c0) lat = k;
        end
        rd_en = 1'b0;
        ps2clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip, input bit glitch,
                              input int pop_k, output int lat);
        logic [10:0] f;
        int l;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        lat = -1;
        for (int i = 0; i < 11; i++) begin
            drive_bit(f[i], glitch, (i == 10) ? pop_k : 0, l);
            if (i == 10) lat = l;
        end
        repeat (HP) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int l;
        send_frame(b, 1'b0, 1'b0, 0, l);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
        n_chk++; if (code !== 8'h00) $display("FAIL reset_code: got %h want 00", code); else n_pass++;
        n_chk++; if (is_ext !== 1'b0) $display("FAIL reset_ext: got %b want 0", is_ext); else n_pass++;
        n_chk++; if (is_break !== 1'b0) $display("FAIL reset_brk: got %b want 0", is_break); else n_pass++;
        n_chk++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else n_pass++;
        n_chk++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else n_pass++;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int lat;
        int e0;
        e0 = n_err_pulse;
        send_frame(8'h1C, 1'b0, 1'b0, 0, lat);
        n_chk++; if (lat !== 7) $display("FAIL single_latency: got %0d want 7", lat); else n_pass++;
        n_chk++; if (valid !== 1'b1) $display("FAIL single_valid: got %b want 1", valid); else n_pass++;
        n_chk++; if (code !== 8'h1C) $display("FAIL single_code: got %h want 1c", code); else n_pass++;
        n_chk++; if (is_ext !== 1'b0 || is_break !== 1'b0)
            $display("FAIL single_flags: got ext=%b brk=%b want 0 0", is_ext, is_break); else n_pass++;
        n_chk++; if (count !== 4'd1) $display("FAIL single_count: got %0d want 1", count); else n_pass++;
        n_chk++; if (n_err_pulse != e0) $display("FAIL single_noerr: got %0d pulses want 0", n_err_pulse - e0); else n_pass++;
        pop();
        n_chk++; if (count !== 4'd0 || valid !== 1'b0)
            $display("FAIL single_pop: got count=%0d valid=%b want 0 0", count, valid); else n_pass++;
        pop();
        n_chk++; if (count !== 4'd0) $display("FAIL empty_pop: got count=%0d want 0", count); else n_pass++;
    endtask

    task automatic test_prefix();
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        n_chk++; if (count !== 4'd1) $display("FAIL prefix_count: got %0d want 1", count); else n_pass++;
        n_chk++; if (code !== 8'h75) $display("FAIL prefix_code: got %h want 75", code); else n_pass++;
        n_chk++; if (is_ext !== 1'b1 || is_break !== 1'b1)
            $display("FAIL prefix_flags: got ext=%b brk=%b want 1 1", is_ext, is_break); else n_pass++;
        pop();
    endtask

    task automatic test_parity();
        int lat;
        int e0;
        e0 = n_err_pulse;
        send_frame(8'h1C, 1'b1, 1'b0, 0, lat);
        n_chk++; if (n_err_pulse - e0 != 1) $display("FAIL parity_err: got %0d pulses want 1", n_err_pulse - e0); else n_pass++;
        n_chk++; if (count !== 4'd0) $display("FAIL parity_drop: got count=%0d want 0", count); else n_pass++;
        send(8'hF0);
        send(8'h1C);
        n_chk++; if (count !== 4'd1 || code !== 8'h1C)
            $display("FAIL parity_next: got count=%0d code=%h want 1 1c", count, code); else n_pass++;
        n_chk++; if (is_ext !== 1'b0 || is_break !== 1'b1)
            $display("FAIL parity_next_flags: got ext=%b brk=%b want 0 1", is_ext, is_break); else n_pass++;
        pop();
    endtask

    task automatic test_overflow();
        int lat;
        logic [7:0] exp_code;
        for (int i = 1; i <= 9; i++) send(8'(i));
        n_chk++; if (count !== 4'd8) $display("FAIL ovf_count: got %0d want 8", count); else n_pass++;
        n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
        n_chk++; if (code !== 8'h01) $display("FAIL ovf_head: got %h want 01", code); else n_pass++;
        // Pop lands on the same edge as the push of 0A.
        send_frame(8'h0A, 1'b0, 1'b0, 7, lat);
        n_chk++; if (count !== 4'd8) $display("FAIL full_pushpop_count: got %0d want 8", count); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            exp_code = (i < 7) ? 8'(i + 2) : 8'h0A;
            n_chk++; if (code !== exp_code)
                $display("FAIL drain_code_%0d: got %h want %h", i, code, exp_code); else n_pass++;
            pop();
        end
        n_chk++; if (count !== 4'd0 || valid !== 1'b0)
            $display("FAIL drain_empty: got count=%0d valid=%b want 0 0", count, valid); else n_pass++;
        n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
    endtask

    task automatic test_glitch();
        int lat;
        int e0;
        e0 = n_err_pulse;
        send_frame(8'h5A, 1'b0, 1'b1, 0, lat);
        n_chk++; if (count !== 4'd1 || code !== 8'h5A)
            $display("FAIL glitch_code: got count=%0d code=%h want 1 5a", count, code); else n_pass++;
        n_chk++; if (n_err_pulse != e0) $display("FAIL glitch_noerr: got %0d pulses want 0", n_err_pulse - e0); else n_pass++;
        pop();
    endtask

    task automatic test_timeout();
        int l;
        int e0;
        e0 = n_err_pulse;
        drive_bit(1'b0, 1'b0, 0, l);
        drive_bit(1'b1, 1'b0, 0, l);
        drive_bit(1'b0, 1'b0, 0, l);
        drive_bit(1'b1, 1'b0, 0, l);
        drive_bit(1'b1, 1'b0, 0, l);
        ps2data = 1'b1;
        repeat (49000) @(posedge clk);
        #1;
        n_chk++; if (n_err_pulse != e0) $display("FAIL timeout_early: got %0d pulses want 0", n_err_pulse - e0); else n_pass++;
        repeat (2000) @(posedge clk);
        #1;
        n_chk++; if (n_err_pulse - e0 != 1) $display("FAIL timeout_err: got %0d pulses want 1", n_err_pulse - e0); else n_pass++;
        send(8'h29);
        n_chk++; if (count !== 4'd1 || code !== 8'h29)
            $display("FAIL timeout_next: got count=%0d code=%h want 1 29", count, code); else n_pass++;
        n_chk++; if (n_err_pulse - e0 != 1) $display("FAIL timeout_next_err: got %0d pulses want 1", n_err_pulse - e0); else n_pass++;
        pop();
    endtask

    task automatic test_reset_midframe();
        int l;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'hF0);
        n_chk++; if (count !== 4'd3) $display("FAIL rmid_pre_count: got %0d want 3", count); else n_pass++;
        drive_bit(1'b0, 1'b0, 0, l);
        drive_bit(1'b1, 1'b0, 0, l);
        ps2data = 1'b0;
        repeat (3) @(posedge clk);
        #1 ps2clk = 1'b0;
        #10 reset = 1'b1;
        #1;
        n_chk++; if (valid !== 1'b0 || count !== 4'd0)
            $display("FAIL rmid_fifo: got valid=%b count=%0d want 0 0", valid, count); else n_pass++;
        n_chk++; if (code !== 8'h00 || is_ext !== 1'b0 || is_break !== 1'b0)
            $display("FAIL rmid_head: got code=%h ext=%b brk=%b want 00 0 0", code, is_ext, is_break); else n_pass++;
        n_chk++; if (overflow !== 1'b0 || frame_err !== 1'b0)
            $display("FAIL rmid_status: got ovf=%b ferr=%b want 0 0", overflow, frame_err); else n_pass++;
        ps2clk = 1'b1;
        ps2data = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        send(8'h4B);
        n_chk++; if (count !== 4'd1 || code !== 8'h4B)
            $display("FAIL rmid_after: got count=%0d code=%h want 1 4b", count, code); else n_pass++;
        n_chk++; if (is_ext !== 1'b0 || is_break !== 1'b0)
            $display("FAIL rmid_flags: got ext=%b brk=%b want 0 0", is_ext, is_break); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_parity();
        test_overflow();
        test_glitch();
        test_timeout();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
